// File: rtl/riscv_v_logic_wb_stage.sv
// ----------------------------------------------------------------------------
// riscv_v_logic_wb_stage
//
// Writeback stage that sits directly after the vector logic ALU. Each accepted
// ALU result is merged byte-by-byte with the prior destination contents
// (bytes without byte_valid keep the old value). The merged result is then
// buffered in a small FIFO and presented to the vector register file over a
// valid/ready handshake. Results with no valid bytes are accepted and counted,
// but they are never stored.
//
// Ports
//   clk, rst_n         clock; synchronous active-low reset
//   flush              discard every buffered entry (and any same-cycle push)
//   in_valid/in_ready  upstream handshake; in_ready depends on occupancy only
//   in_result          {data[DATA_WIDTH-1:0], byte_valid[NUM_BYTES-1:0]}
//   in_vd              destination vector register index
//   in_old_vd          prior destination register contents
//   wb_valid/wb_ready  register-file handshake for the head entry
//   wb_vd, wb_data,
//   wb_byte_en         head entry fields (all zero while the FIFO is empty)
//   retire_count       number of completed writebacks (wraps)
//   drop_count         number of discarded all-zero-byte_valid results (wraps)
// ----------------------------------------------------------------------------
module riscv_v_logic_wb_stage #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned NUM_BYTES  = DATA_WIDTH / 8,
    parameter int unsigned VREG_IDX_W = 5,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH+NUM_BYTES-1:0]  in_result,
    input  logic [VREG_IDX_W-1:0]            in_vd,
    input  logic [DATA_WIDTH-1:0]            in_old_vd,
    output logic                             wb_valid,
    input  logic                             wb_ready,
    output logic [VREG_IDX_W-1:0]            wb_vd,
    output logic [DATA_WIDTH-1:0]            wb_data,
    output logic [NUM_BYTES-1:0]             wb_byte_en,
    output logic [CNT_W-1:0]                 retire_count,
    output logic [CNT_W-1:0]                 drop_count
);

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [VREG_IDX_W-1:0] vd_q   [DEPTH];
    logic [NUM_BYTES-1:0]  be_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q,    occ_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic [CNT_W-1:0] drop_q,   drop_d;

    // ------------------------------------------------------------------
    // Input decode and byte merge
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] in_data;
    logic [NUM_BYTES-1:0]  in_be;
    logic [DATA_WIDTH-1:0] merged;

    assign in_data = in_result[DATA_WIDTH+NUM_BYTES-1:NUM_BYTES];
    assign in_be   = in_result[NUM_BYTES-1:0];

    // Undisturbed policy: bytes not written by the ALU keep the old value.
    always_comb begin
        merged = in_old_vd;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (in_be[i]) begin
                merged[8*i +: 8] = in_data[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic full;
    logic empty;
    logic push_fire;
    logic push_store;
    logic push_drop;
    logic pop_fire;

    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);

    // in_ready comes from registered occupancy only, so a pop while full
    // frees the slot for the next cycle, not the current one.
    assign in_ready = ~full;

    assign push_fire  = in_valid & ~full;
    assign push_store = push_fire & (|in_be);
    assign push_drop  = push_fire & ~(|in_be);
    assign pop_fire   = ~empty & wb_ready;

    // ------------------------------------------------------------------
    // Next-state logic (flush overrides push/pop; reset handled below)
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        retire_d = retire_q;
        drop_d   = drop_q;

        if (flush) begin
            // Same-cycle push and pop are both discarded and left uncounted.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_store) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                retire_d = retire_q + CNT_W'(1);
            end
            if (push_drop) begin
                drop_d = drop_q + CNT_W'(1);
            end
            case ({push_store, pop_fire})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            retire_q <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            retire_q <= retire_d;
            drop_q   <= drop_d;
        end
    end

    // Entry storage needs no reset: nothing is visible unless occupancy
    // covers it, and the outputs are forced to zero while empty.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_store) begin
            data_q[wr_ptr_q] <= merged;
            vd_q[wr_ptr_q]   <= in_vd;
            be_q[wr_ptr_q]   <= in_be;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head entry only, no path from in_* to wb_*
    // ------------------------------------------------------------------
    assign wb_valid     = ~empty;
    assign wb_data      = empty ? '0 : data_q[rd_ptr_q];
    assign wb_vd        = empty ? '0 : vd_q[rd_ptr_q];
    assign wb_byte_en   = empty ? '0 : be_q[rd_ptr_q];
    assign retire_count = retire_q;
    assign drop_count   = drop_q;

endmodule

// File: doc/riscv_v_logic_wb_stage.md
Name: riscv_v_logic_wb_stage

Overview:
- Writeback stage directly downstream of the vector logic ALU.
- Accepts the packed ALU result (128-bit data plus 16 byte-valid bits) with the destination register index and the prior destination value.
- Merges per byte: valid bytes take the new data, other bytes keep the prior value (undisturbed policy).
- Buffers merged results in a 2-entry FIFO and presents them to the register file over a valid/ready handshake.

Parameters:
DATA_WIDTH, 128, vector data width in bits
NUM_BYTES, 16, DATA_WIDTH/8; byte lanes
VREG_IDX_W, 5, vector register index width
DEPTH, 2, FIFO entries (power of 2; RTL must hold for DEPTH=2 and 4)
CNT_W, 16, retire counter width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
flush  input  1  discard all buffered entries
in_valid  input  1  ALU result valid
in_ready  output  1  stage can accept
in_result  input  DATA_WIDTH+NUM_BYTES  {data[143:16], byte_valid[15:0]}, ALU result format
in_vd  input  VREG_IDX_W  destination register
in_old_vd  input  DATA_WIDTH  prior destination contents
wb_valid  output  1  writeback entry available
wb_ready  input  1  register file accepts
wb_vd  output  VREG_IDX_W  destination register of head entry
wb_data  output  DATA_WIDTH  merged data of head entry
wb_byte_en  output  NUM_BYTES  byte_valid of head entry
retire_count  output  CNT_W  writebacks completed, wraps
drop_count  output  CNT_W  all-zero-byte_valid results discarded, wraps

Behaviour:
- Reset (rst_n=0 at edge): FIFO empty, pointers 0. Outputs: wb_valid=0, in_ready=1, retire_count=0, drop_count=0. wb_data/wb_vd/wb_byte_en=0 while empty.
- Reset mid-operation discards all entries. No output handshake completes in the reset cycle.
- Push: in_valid && in_ready at edge.
  - Merge per byte i: merged[8i+7:8i] = byte_valid[i] ? data byte i : in_old_vd byte i.
  - Store {in_vd, merged, byte_valid}.
- Drop: a push with byte_valid==0 is accepted (in_ready honoured) but not stored; drop_count += 1.
- in_ready = !full, derived from registered occupancy only, never from wb_ready. When full, a pop in the same cycle does not allow a push; in_ready rises the following cycle.
- Pop: wb_valid && wb_ready at edge. Head advances; retire_count += 1.
- wb_valid = !empty. wb_* driven combinationally from the head entry register. No combinational path from in_* to wb_*.
- Latency: a result pushed at edge N appears on wb_* in cycle N+1 if the FIFO was empty. Otherwise it follows older entries in order.
- Simultaneous push and pop when not full and not empty: occupancy unchanged, order preserved.
- While wb_valid && !wb_ready, wb_* must hold stable.
- Flush at edge: FIFO emptied, wb_valid=0 next cycle.
  - A same-cycle push is discarded.
  - A same-cycle pop is not counted.
  - Counters are otherwise unaffected.
  - Priority order: rst_n > flush > push/pop.
- Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits. Counters wrap from all-ones to 0.
- Pushes are ignored when in_valid=0. Pops are ignored when wb_ready=0 or the FIFO is empty.

Test Plan:
- Reset then single push: byte_valid=16'h00FF, data=all 0xAA, old=all 0x55, vd=3 → next cycle wb_valid=1, wb_vd=3, wb_data=128'h5555..55_AAAA..AA (upper 8 bytes 0x55), wb_byte_en=16'h00FF. Pop → retire_count=1.
- Backpressure: wb_ready=0, push A then B → in_ready=0 after second push. Third in_valid is not accepted. wb_* holds A. Raise wb_ready → A, then B, in order; in_ready returns 1 the cycle after the first pop.
- Drop: push with byte_valid=0 → wb_valid stays 0, drop_count=1, in_ready stays 1.
- Streaming: continuous in_valid with wb_ready=1, 10 pushes with distinct vd → 10 writebacks, 1-cycle latency each, no bubbles, retire_count=10.
- Flush with FIFO full plus a simultaneous push → wb_valid=0 next cycle, in_ready=1, retire_count unchanged, pushed entry never appears.
- Reset asserted with 2 entries held → all outputs at reset values next cycle. Counter wrap: preload via 65536 pops → retire_count=0.
